// File: rtl/hmi_pkg.sv
// hmi_pkg -- shared definitions for the host command decoder (cu_hmi_mc).
//   Byte class codes (din[7:6]), fixed command strobe indices, the broadcast
//   select payload and the decoder FSM state type.
package hmi_pkg;

  // Byte classes carried in bits [7:6] of every received byte
  localparam logic [1:0] CLS_SEL = 2'b11;
  localparam logic [1:0] CLS_CMD = 2'b01;
  localparam logic [1:0] CLS_ADR = 2'b10;
  localparam logic [1:0] CLS_RD  = 2'b00;

  // Fixed command strobe indices understood by the TDC control logic
  localparam int CMD_RESET    = 1;
  localparam int CMD_RST_DAC  = 2;
  localparam int CMD_INC_DAC  = 3;
  localparam int CMD_RST_TEST = 5;
  localparam int CMD_STARTUP  = 6;

  // Select payload that addresses every board at once
  localparam logic [5:0] BCAST = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACK    = 2'd2
  } hmi_state_t;

endpackage

// File: rtl/hmi_edge_buf.sv
// hmi_edge_buf -- rising-edge detector on the receiver byte-valid level plus
// a 1-deep pending byte register for bytes that arrive while the decoder is
// busy.
//   clk, res   : clock, synchronous active-high reset
//   din_rdy    : receiver byte-valid level
//   din        : received byte
//   take       : decoder consumes din directly this cycle (no buffering)
//   pop        : decoder empties the pending register this cycle
//   din_edge   : single-cycle rising edge of din_rdy
//   pend_valid : pending register full
//   pend_data  : pending byte
//   ovf        : sticky, a byte arrived while pending was full and was lost
module hmi_edge_buf (
  input  logic       clk,
  input  logic       res,
  input  logic       din_rdy,
  input  logic [7:0] din,
  input  logic       take,
  input  logic       pop,
  output logic       din_edge,
  output logic       pend_valid,
  output logic [7:0] pend_data,
  output logic       ovf
);

  logic din_rdy_q;

  assign din_edge = din_rdy & ~din_rdy_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (res) begin
      din_rdy_q  <= 1'b0;
      pend_valid <= 1'b0;
      // NOTE: the data register is reset too so the block comes out of reset
      // fully defined; it costs nothing at this size.
      pend_data  <= 8'h00;
      ovf        <= 1'b0;
    end else begin
      din_rdy_q <= din_rdy;
      if (pop) begin
        pend_valid <= 1'b0;
      end
      // A byte finding the register full is dropped even if the register is
      // being emptied in the same cycle.
      if (din_edge && !take) begin
        if (pend_valid) begin
          ovf <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_data  <= din;
        end
      end
    end
  end

endmodule

// File: rtl/cu_hmi_mc.sv
// cu_hmi_mc -- host command decoder. Accepts bytes from the UART receiver on
// the rising edge of din_rdy, decodes the class in din[7:6] and drives
// one-hot command strobes, a read pulse, the device-select state and the
// packet address. Optionally returns one acknowledge byte per decoded byte.
//   clk, res          : clock, synchronous active-high reset
//   din_rdy, din      : receiver byte-valid level and byte
//   dev_addr          : this board's device address
//   cmd_strobe        : one-cycle command pulses (index = command number)
//   cmd_read          : one-cycle read pulse
//   selected          : device currently selected
//   dev_sel_byte      : last select byte received
//   pkt_addr          : current packet address
//   rsp_valid/data    : acknowledge byte {ok, class, byte[4:0]} to transmitter
//   rsp_ready         : transmitter accepts rsp_data
//   err_ovf, err_cmd  : sticky byte-lost / illegal-command flags
module cu_hmi_mc
  import hmi_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int PKT_ADDR_W = 5,
  parameter int NCMD       = 8,
  parameter int ACK_EN     = 1,
  parameter int HI_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  din_rdy,
  input  logic [7:0]            din,
  input  logic [ADDR_W-1:0]     dev_addr,
  output logic [NCMD-1:0]       cmd_strobe,
  output logic                  cmd_read,
  output logic                  selected,
  output logic [7:0]            dev_sel_byte,
  output logic [PKT_ADDR_W-1:0] pkt_addr,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  input  logic                  rsp_ready,
  output logic                  err_ovf,
  output logic                  err_cmd
);

  localparam int         CNT_W  = $clog2(HI_TIMEOUT + 1);
  localparam logic [6:0] NCMD_L = 7'(NCMD);

  hmi_state_t       state, state_d;
  logic [7:0]       byte_q;
  logic             take, pop;
  logic             din_edge, pend_valid;
  logic [7:0]       pend_data;
  logic [1:0]       cls;
  logic [5:0]       payload;
  logic             sel_match, cmd_ok;
  logic [9:0]       addr_full;
  logic [NCMD-1:0]  strobe_d;
  logic             read_d, bad_d;
  logic [4:0]       hi_stage;
  logic [CNT_W-1:0] hi_cnt;

  hmi_edge_buf u_edge_buf (
    .clk        (clk),
    .res        (res),
    .din_rdy    (din_rdy),
    .din        (din),
    .take       (take),
    .pop        (pop),
    .din_edge   (din_edge),
    .pend_valid (pend_valid),
    .pend_data  (pend_data),
    .ovf        (err_ovf)
  );

  // ---------------------------------------------------------------- FSM
  // IDLE with a full pending register can occur when a byte lands in the
  // last DECODE/ACK cycle; it is drained before any new edge can arrive.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state;
    pop     = 1'b0;
    take    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        take = !pend_valid;
        if (pend_valid) begin
          state_d = ST_DECODE;
          pop     = 1'b1;
        end else if (din_edge) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (ACK_EN != 0) begin
          state_d = ST_ACK;
        end else if (pend_valid) begin
          state_d = ST_DECODE;
          pop     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (rsp_ready) begin
          if (pend_valid) begin
            state_d = ST_DECODE;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= ST_IDLE;
      byte_q <= 8'h00;
    end else begin
      state <= state_d;
      if (pop) begin
        byte_q <= pend_data;
      end else if (take && din_edge) begin
        byte_q <= din;
      end
    end
  end

  assign rsp_valid = (ACK_EN != 0) && (state == ST_ACK);

  // ------------------------------------------------------------- decode
  assign cls       = byte_q[7:6];
  assign payload   = byte_q[5:0];
  assign sel_match = (byte_q[ADDR_W-1:0] == dev_addr) || (payload == BCAST);
  assign cmd_ok    = (payload != 6'd0) && ({1'b0, payload} < NCMD_L);
  assign addr_full = {hi_stage, byte_q[4:0]};

  always_comb begin
    strobe_d = '0;
    read_d   = 1'b0;
    bad_d    = 1'b0;
    unique case (cls)
      CLS_CMD: begin
        if (selected && cmd_ok) begin
          for (int i = 0; i < NCMD; i++) begin
            strobe_d[i] = (payload == 6'(i));
          end
        end else begin
          bad_d = 1'b1;
        end
      end
      CLS_RD: begin
        if (selected) read_d = 1'b1;
        else          bad_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cmd_strobe   <= '0;
      cmd_read     <= 1'b0;
      selected     <= 1'b0;
      dev_sel_byte <= 8'h00;
      pkt_addr     <= '0;
      rsp_data     <= 8'h00;
      err_cmd      <= 1'b0;
      hi_stage     <= 5'd0;
      hi_cnt       <= '0;
    end else begin
      cmd_strobe <= '0;
      cmd_read   <= 1'b0;

      // An unpaired high-address byte expires HI_TIMEOUT cycles after it
      // was decoded; a low byte decoded in the expiry cycle still sees it.
      if (hi_cnt != '0) begin
        hi_cnt <= hi_cnt - CNT_W'(1);
        if (hi_cnt == CNT_W'(1)) hi_stage <= 5'd0;
      end

      if (state == ST_DECODE) begin
        cmd_strobe <= strobe_d;
        cmd_read   <= read_d;
        rsp_data   <= {~bad_d, cls, byte_q[4:0]};
        if (bad_d) err_cmd <= 1'b1;
        unique case (cls)
          CLS_SEL: begin
            dev_sel_byte <= byte_q;
            selected     <= sel_match;
          end
          CLS_ADR: begin
            if (byte_q[5]) begin
              hi_stage <= byte_q[4:0];
              hi_cnt   <= CNT_W'(HI_TIMEOUT);
            end else begin
              pkt_addr <= addr_full[PKT_ADDR_W-1:0];
              hi_stage <= 5'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cu_hmi_mc.sv
// tb_cu_hmi_mc -- self-checking bench for cu_hmi_mc. Directed scenarios plus
// randomized bytes, checked against a transaction-level reference model.
// A second instance with a 10-bit packet address runs on the same stimulus.
module tb_cu_hmi_mc;
  import hmi_pkg::*;

  localparam int HI_TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       din_rdy = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] dev_addr = 3'b111;
  logic       rsp_ready = 1'b1;

  logic [7:0] cmd_strobe, dev_sel_byte, rsp_data;
  logic       cmd_read, selected, rsp_valid, err_ovf, err_cmd;
  logic [4:0] pkt_addr;

  logic [7:0] w_cmd_strobe, w_dev_sel_byte, w_rsp_data;
  logic       w_cmd_read, w_selected, w_rsp_valid, w_err_ovf, w_err_cmd;
  logic [9:0] w_pkt_addr;

  cu_hmi_mc dut (
    .clk(clk), .res(res), .din_rdy(din_rdy), .din(din), .dev_addr(dev_addr),
    .cmd_strobe(cmd_strobe), .cmd_read(cmd_read), .selected(selected),
    .dev_sel_byte(dev_sel_byte), .pkt_addr(pkt_addr), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .err_ovf(err_ovf), .err_cmd(err_cmd)
  );

  cu_hmi_mc #(.PKT_ADDR_W(10)) dut_w (
    .clk(clk), .res(res), .din_rdy(din_rdy), .din(din), .dev_addr(dev_addr),
    .cmd_strobe(w_cmd_strobe), .cmd_read(w_cmd_read), .selected(w_selected),
    .dev_sel_byte(w_dev_sel_byte), .pkt_addr(w_pkt_addr), .rsp_valid(w_rsp_valid),
    .rsp_data(w_rsp_data), .rsp_ready(rsp_ready), .err_ovf(w_err_ovf), .err_cmd(w_err_cmd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // rsp_ready: 0 = always ready, 1 = stalled, 2 = random per cycle
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk);
    #2;
    rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // ------------------------------------------------------------ monitor
  typedef struct { logic [7:0] strobe; logic rd; int cyc; } pulse_t;
  typedef struct { logic [7:0] data; int cyc; } ack_t;
  pulse_t obs_p[$], exp_p[$];
  ack_t   obs_a[$], exp_a[$];

  bit         in_ack = 0;
  int         ack_start;
  logic [7:0] ack_hold;

  always @(negedge clk) begin
    pulse_t p;
    ack_t   a;
    if ((cmd_strobe != 8'h00) || (cmd_read == 1'b1)) begin
      p.strobe = cmd_strobe; p.rd = cmd_read; p.cyc = cyc;
      obs_p.push_back(p);
    end
    if (rsp_valid == 1'b1) begin
      if (!in_ack) begin
        in_ack = 1; ack_start = cyc; ack_hold = rsp_data;
      end else begin
        check("ack_stable", rsp_data, ack_hold);
      end
      if (rsp_ready) begin
        a.data = rsp_data; a.cyc = ack_start;
        obs_a.push_back(a);
        in_ack = 0;
      end
    end else begin
      in_ack = 0;
    end
  end

  // ------------------------------------------------------ reference model
  bit         m_sel, m_errc, m_ovf;
  logic [7:0] m_dsb;
  int         m_pkt, m_hi, m_hi_t;

  task automatic model_reset();
    m_sel = 0; m_errc = 0; m_ovf = 0; m_dsb = 8'h00; m_pkt = 0; m_hi = 0; m_hi_t = 0;
  endtask

  // t is the cycle in which the byte is decoded
  task automatic model_decode(input logic [7:0] b, input int t,
                              output logic [7:0] s, output logic rd, output logic [7:0] a);
    int c, p, hi_eff;
    bit bad;
    c = int'(b) / 64;
    p = int'(b) % 64;
    s = 8'h00; rd = 1'b0; bad = 0;
    case (c)
      3: begin
        m_dsb = b;
        m_sel = ((p % 8) == int'(dev_addr)) || (p == 63);
      end
      1: begin
        if (m_sel && p >= 1 && p < 8) s = 8'(1 << p);
        else bad = 1;
      end
      2: begin
        if (p >= 32) begin
          m_hi = p - 32; m_hi_t = t;
        end else begin
          hi_eff = (t - m_hi_t <= HI_TIMEOUT) ? m_hi : 0;
          m_pkt  = hi_eff * 32 + p;
          m_hi   = 0;
        end
      end
      default: begin
        if (m_sel) rd = 1'b1;
        else bad = 1;
      end
    endcase
    if (bad) m_errc = 1;
    a = 8'((bad ? 0 : 128) + c * 32 + p % 32);
  endtask

  // ------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_regs();
    check("selected", selected, m_sel);
    check("dev_sel_byte", dev_sel_byte, m_dsb);
    check("pkt_addr", pkt_addr, m_pkt % 32);
    check("pkt_addr_w", w_pkt_addr, m_pkt % 1024);
    check("err_cmd", err_cmd, m_errc);
    check("err_ovf", err_ovf, m_ovf);
  endtask

  task automatic cmp_queues();
    pulse_t op, ep;
    ack_t   oa, ea;
    check("pulse_count", obs_p.size(), exp_p.size());
    while (obs_p.size() > 0 && exp_p.size() > 0) begin
      op = obs_p.pop_front(); ep = exp_p.pop_front();
      check("cmd_strobe", op.strobe, ep.strobe);
      check("cmd_read", op.rd, ep.rd);
      check("pulse_cycle", op.cyc, ep.cyc);
    end
    obs_p.delete(); exp_p.delete();
    check("ack_count", obs_a.size(), exp_a.size());
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      oa = obs_a.pop_front(); ea = exp_a.pop_front();
      check("rsp_data", oa.data, ea.data);
      if (ea.cyc >= 0) check("ack_cycle", oa.cyc, ea.cyc);
    end
    obs_a.delete(); exp_a.delete();
  endtask

  // One byte from an idle decoder; called at posedge+1, din_rdy low before.
  task automatic xfer(input logic [7:0] b, input int hold);
    int e, n, limit;
    logic [7:0] s, a;
    logic rd;
    pulse_t p;
    ack_t   k;
    e = cyc;
    din = b;
    din_rdy = 1'b1;
    model_decode(b, e + 1, s, rd, a);
    if (s != 8'h00 || rd) begin
      p.strobe = s; p.rd = rd; p.cyc = e + 2;
      exp_p.push_back(p);
    end
    k.data = a; k.cyc = e + 2;
    exp_a.push_back(k);
    n = 0;
    limit = hold + 400;
    while ((din_rdy || obs_a.size() < exp_a.size()) && n <= limit) begin
      step();
      n++;
      if (n >= hold) din_rdy = 1'b0;
    end
    din_rdy = 1'b0;
    check("xfer_done", n <= limit, 1);
    repeat (3) step();
    cmp_queues();
    check_regs();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------------------------------------------------- stimulus
  initial begin
    int e, c, p, w;
    logic [7:0] s, a;
    logic rd;
    ack_t k;

    model_reset();
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    check("rst_cmd_strobe", cmd_strobe, 0);
    check("rst_cmd_read", cmd_read, 0);
    check("rst_selected", selected, 0);
    check("rst_dev_sel_byte", dev_sel_byte, 0);
    check("rst_pkt_addr", pkt_addr, 0);
    check("rst_pkt_addr_w", w_pkt_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_cmd", err_cmd, 0);
    step();

    // 1: long level yields a single byte
    xfer(8'hC7, 163);
    check("t1_selected", selected, 1);

    // 2: select, deselect, unselected command
    xfer(8'hC7, 2);
    xfer(8'hC0, 2);
    check("t2_deselected", selected, 0);
    xfer(8'h41, 2);
    check("t2_err_cmd", err_cmd, 1);

    // 3: fixed command strobes
    xfer(8'hC7, 1);
    xfer(8'(64 + CMD_RESET), 1);
    xfer(8'(64 + CMD_RST_DAC), 3);
    xfer(8'(64 + CMD_INC_DAC), 1);
    xfer(8'(64 + CMD_RST_TEST), 5);
    xfer(8'(64 + CMD_STARTUP), 1);

    // 4: broadcast, wide address, hi-stage timeout boundary
    dev_addr = 3'b010;
    xfer(8'hFF, 2);
    check("t4_bcast", selected, 1);
    dev_addr = 3'b111;
    xfer(8'hA3, 2);
    xfer(8'h85, 2);
    check("t4_wide", w_pkt_addr, 10'h065);
    e = cyc;
    xfer(8'hA3, 2);
    wait_until(e + HI_TIMEOUT);
    xfer(8'h85, 2);
    check("t4_tmo_last", w_pkt_addr, 10'h065);
    e = cyc;
    xfer(8'hA3, 2);
    wait_until(e + HI_TIMEOUT + 1);
    xfer(8'h85, 2);
    check("t4_tmo_expired", w_pkt_addr, 10'h005);

    // 5: backpressure, pending byte, overflow
    rdy_mode = 1;
    e = cyc;
    din = 8'hC7; din_rdy = 1'b1; step(); din_rdy = 1'b0; step();
    din = 8'hFF; din_rdy = 1'b1; step(); din_rdy = 1'b0; step();
    din = 8'hC0; din_rdy = 1'b1; step(); din_rdy = 1'b0;
    repeat (6) step();
    check("t5_no_ack_yet", obs_a.size(), 0);
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_data", rsp_data, 8'hE7);
    check("t5_err_ovf", err_ovf, 1);
    model_decode(8'hC7, e + 1, s, rd, a);
    k.data = a; k.cyc = e + 2; exp_a.push_back(k);
    model_decode(8'hFF, e + 8, s, rd, a);
    k.data = a; k.cyc = -1; exp_a.push_back(k);
    m_ovf = 1;
    rdy_mode = 0;
    w = 0;
    while (obs_a.size() < 2 && w < 50) begin step(); w++; end
    check("t5_drain", w < 50, 1);
    repeat (3) step();
    cmp_queues();
    check_regs();

    // 6: reset while an acknowledge is stalled
    rdy_mode = 1;
    din = 8'hC7; din_rdy = 1'b1; step(); din_rdy = 1'b0;
    w = 0;
    while (rsp_valid !== 1'b1 && w < 20) begin step(); w++; end
    check("t6_ack_up", rsp_valid, 1);
    step();
    res = 1'b1; step(); res = 1'b0;
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_selected", selected, 0);
    check("t6_pkt_addr", pkt_addr, 0);
    check("t6_err_cmd", err_cmd, 0);
    check("t6_err_ovf", err_ovf, 0);
    model_reset();
    rdy_mode = 0;
    repeat (3) step();
    check("t6_no_ack", obs_a.size(), 0);
    obs_a.delete(); obs_p.delete();

    // random bytes with random transmitter backpressure
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) dev_addr = 3'($urandom_range(0, 7));
      c = $urandom_range(0, 3);
      p = $urandom_range(0, 63);
      if (c == 3) begin
        case ($urandom_range(0, 2))
          0: p = (p / 8) * 8 + int'(dev_addr);
          1: p = 63;
          default: ;
        endcase
      end else if (c == 1) begin
        p = $urandom_range(0, 9);
      end
      xfer(8'(c * 64 + p), $urandom_range(1, 12));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_hmi_mc.md
Name: cu_hmi_mc

Overview:
- Parametrised successor to the host command decoder.
- Takes bytes from the UART receiver (din, level-type din_rdy) and decodes the 2-bit class in din[7:6]:
  - device select,
  - command,
  - packet address (one- or two-byte),
  - read.
- Drives one-hot command strobes to the TDC control logic.
- New capabilities: generic command count, wide packet address, broadcast select, a 1-deep input pending buffer, an acknowledge byte stream back to the UART transmitter, and sticky error flags.

Parameters:
- ADDR_W, 3: device address width, 1..5.
- PKT_ADDR_W, 5: packet address width, 1..10.
- NCMD, 8: command strobe count, 1..32.
- ACK_EN, 1: 1 = emit an acknowledge byte per decoded byte; 0 = rsp_valid is tied to 0.
- HI_TIMEOUT, 4096: cycles an unpaired high-address byte is retained.

Ports:
- clk, in, 1: system clock.
- res, in, 1: synchronous reset, active-high.
- din_rdy, in, 1: receiver byte-valid level. It is held high for many cycles.
- din, in, 8: received byte, stable while din_rdy is high.
- dev_addr, in, ADDR_W: this board's device address.
- cmd_strobe, out, NCMD: one-cycle command pulses.
- cmd_read, out, 1: one-cycle read pulse.
- selected, out, 1: device currently selected.
- dev_sel_byte, out, 8: last select byte received.
- pkt_addr, out, PKT_ADDR_W: current packet address.
- rsp_valid, out, 1: acknowledge byte valid.
- rsp_data, out, 8: acknowledge byte.
- rsp_ready, in, 1: transmitter accepts rsp_data.
- err_ovf, out, 1: sticky, a byte was lost.
- err_cmd, out, 1: sticky, illegal or unselected command.

Behaviour:
- Clock and reset: single clock clk. res is synchronous and active-high.
- Reset values: all outputs 0. Internal state after reset: FSM in IDLE, pending empty, hi_stage 0, timeout counter 0, din_rdy_q 0.
- Byte acceptance: only on the rising edge of din_rdy (din_rdy=1 and din_rdy_q=0). din is captured in that cycle. A high level held for hundreds of cycles yields exactly one byte.
- FSM states:
  - IDLE: on edge, go to DECODE with byte_q=din.
  - DECODE: one cycle. Decode actions are applied; strobe, register and error outputs are registered and visible in the following cycle. Then go to ACK if ACK_EN=1, else IDLE or DECODE (if pending is full).
  - ACK: rsp_valid=1 and rsp_data held stable until rsp_ready=1 is sampled. Then go to DECODE if pending is full (pending is emptied into byte_q), else IDLE.
- Latency: strobe/cmd_read is high exactly 2 cycles after the edge cycle, for 1 cycle. rsp_valid rises in the same cycle as the strobe.
- Pending buffer: an edge in DECODE or ACK loads pending. An edge while pending is already full drops the byte and sets err_ovf. The in-flight and pending bytes are kept.
- Class 2'b11 (select):
  - dev_sel_byte <= byte.
  - selected <= (byte[ADDR_W-1:0]==dev_addr) or (byte[5:0]==6'h3F, broadcast).
  - Any other address deselects.
- Class 2'b01 (command):
  - If selected and byte[5:0] < NCMD and byte[5:0] != 0: cmd_strobe[byte[5:0]] pulses.
  - Otherwise: no strobe, set err_cmd.
  - Fixed mapping: 1 reset, 2 rst_dac, 3 inc_dac, 5 rst_test, 6 startup.
- Class 2'b10 (address):
  - byte[5]=1: hi_stage <= byte[4:0], timeout counter loaded with HI_TIMEOUT.
  - byte[5]=0: pkt_addr <= {hi_stage, byte[4:0]} truncated to PKT_ADDR_W, then hi_stage cleared.
  - Address bytes are accepted regardless of selected.
- Hi-stage timeout: the counter decrements every cycle while nonzero. When it reaches 0 while hi_stage is nonzero, hi_stage is cleared. A simultaneous low byte in that same cycle uses the old hi_stage.
- Class 2'b00 (read): if selected, cmd_read pulses; else set err_cmd.
- Acknowledge byte: rsp_data = {ok, class[1:0], byte[4:0]}.
  - ok=0 when the byte set err_cmd, else 1.
  - Acknowledges are produced for every decoded byte, selected or not.
- Reset mid-operation: res overrides everything in the same edge. A pending byte and an in-progress acknowledge are discarded, and rsp_valid drops the next cycle.
- Error clear: err_ovf and err_cmd clear only on res.

Decomposition:
- Shared package hmi_pkg holds:
  - class codes CLS_SEL=2'b11, CLS_CMD=2'b01, CLS_ADR=2'b10, CLS_RD=2'b00;
  - command indices CMD_RESET=1, CMD_RST_DAC=2, CMD_INC_DAC=3, CMD_RST_TEST=5, CMD_STARTUP=6;
  - BCAST=6'h3F;
  - the FSM state enum.
- One sub-module, hmi_edge_buf: din_rdy edge detector plus 1-deep pending register with overflow flag.

Test Plan:
All tests use dev_addr=3'b111, default parameters and rsp_ready=1, unless stated otherwise.
1. Single edge: din=8'hC7 with din_rdy high for 163 cycles -> selected=1, dev_sel_byte=C7, exactly one rsp_valid pulse with rsp_data=8'hE7.
2. Select then deselect: 8'hC7 then 8'hC0 -> selected returns to 0. A following 8'h41 gives no cmd_strobe, err_cmd=1, rsp_data=8'h21.
3. Command strobes: select, then commands 41, 42, 43, 45, 46 -> cmd_strobe equals 01<<1, 1<<2, 1<<3, 1<<5, 1<<6 in turn. Each pulse is 1 cycle wide, 2 cycles after its edge.
4. Broadcast and wide address:
   - Broadcast: with dev_addr=3'b010, send 8'hFF -> selected=1.
   - Wide address: with PKT_ADDR_W=10, send 8'hA3 then 8'h85 -> pkt_addr=10'h065.
   - Timeout: 8'hA3, wait HI_TIMEOUT+1 cycles, then 8'h85 -> pkt_addr=10'h005.
5. Backpressure and overflow: rsp_ready=0 with three edges -> first byte held in ACK, second byte pending, third byte dropped and err_ovf=1. After releasing rsp_ready, two acknowledges are seen in order.
6. Reset mid-acknowledge: res for 1 cycle while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0, selected=0, pkt_addr=0 and error flags cleared on the next cycle.
